// File: rtl/seg_display_scanner.sv
// seg_display_scanner
// Multiplexed 7-segment display driver with a built-in BCD event counter.
// Counts rising edges of tact_count, scans NUM_DIGITS digits one slot at a
// time and overlays status glyphs: stop (all 8s) beats the blinking turn
// indicators, which beat the counter value.
//
// Ports:
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   tact_count     async level, every rising edge increments the counter
//   clear_count    synchronous counter clear, active-high
//   stop           async level, stop status
//   semnal_stanga  async level, left turn indicator
//   semnal_dreapta async level, right turn indicator
//   digit_en       one-hot digit select, bit 0 = leftmost digit
//   seg            segments {a,b,c,d,e,f,g}, polarity set by SEG_ACTIVE_LOW
//   count_wrap     one-cycle pulse when the counter rolls over from all 9s
module seg_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int CNT_DIGITS     = 2,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tact_count,
  input  logic                  clear_count,
  input  logic                  stop,
  input  logic                  semnal_stanga,
  input  logic                  semnal_dreapta,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [6:0]            seg,
  output logic                  count_wrap
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  // Glyphs are kept active-high; polarity is applied only at the output register.
  localparam logic [6:0] GLYPH_EIGHT = 7'b1111111;
  localparam logic [6:0] GLYPH_DASH  = 7'b0000001;
  localparam logic [6:0] GLYPH_LEFT  = 7'b1001111;
  localparam logic [6:0] GLYPH_RIGHT = 7'b1111001;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_POL     = {7{SEG_ACTIVE_LOW}};

  // Synchroniser bit order: {semnal_dreapta, semnal_stanga, stop, tact_count}
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic       tact_prev;
  logic       tact_edge;
  logic       stop_s;
  logic       stanga_s;
  logic       dreapta_s;
  logic       turn_active;

  logic [3:0] bcd_q    [CNT_DIGITS];
  logic [3:0] bcd_next [CNT_DIGITS];
  logic       wrap_next;

  logic [SCAN_W-1:0]  prescaler;
  logic               scan_tick;
  logic [IDX_W-1:0]   scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_visible;

  logic [6:0]         slot_glyph;
  logic [3:0]         count_digit;
  logic               count_shown;

  function automatic logic [6:0] bcd_to_glyph(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  // Two-flop synchronisers for all asynchronous level inputs, plus the
  // delayed copy of tact_count used to find its rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1     <= '0;
      sync2     <= '0;
      tact_prev <= 1'b0;
    end else begin
      sync1     <= {semnal_dreapta, semnal_stanga, stop, tact_count};
      sync2     <= sync1;
      tact_prev <= sync2[0];
    end
  end

  assign tact_edge   = sync2[0] & ~tact_prev;
  assign stop_s      = sync2[1];
  assign stanga_s    = sync2[2];
  assign dreapta_s   = sync2[3];
  assign turn_active = stanga_s | dreapta_s;

  // BCD increment with ripple carry through all decades in one cycle.
  // The rollover flag is only meaningful when every decade currently holds 9.
  always_comb begin : bcd_increment
    logic carry;
    logic all_nines;
    carry     = tact_edge;
    all_nines = 1'b1;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      bcd_next[i] = bcd_q[i];
      if (bcd_q[i] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (bcd_q[i] == 4'd9) begin
          bcd_next[i] = 4'd0;
        end else begin
          bcd_next[i] = bcd_q[i] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    wrap_next = tact_edge & all_nines;
  end

  // Counter register; a clear takes priority and also suppresses the wrap pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CNT_DIGITS; i++) bcd_q[i] <= 4'd0;
      count_wrap <= 1'b0;
    end else if (clear_count) begin
      for (int i = 0; i < CNT_DIGITS; i++) bcd_q[i] <= 4'd0;
      count_wrap <= 1'b0;
    end else begin
      bcd_q      <= bcd_next;
      count_wrap <= wrap_next;
    end
  end

  // Blink timer only runs while a turn indicator is on, so each new
  // indication starts with a full visible half-period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt     <= '0;
      blink_visible <= 1'b1;
    end else if (!turn_active) begin
      blink_cnt     <= '0;
      blink_visible <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt     <= '0;
      blink_visible <= ~blink_visible;
    end else begin
      blink_cnt     <= blink_cnt + 1'b1;
    end
  end

  // Content for the slot about to be driven, chosen by overlay priority.
  // Counter decades are right-aligned: decade 0 lands on the rightmost digit.
  always_comb begin
    count_digit = 4'd0;
    count_shown = 1'b0;
    for (int i = 0; i < CNT_DIGITS; i++) begin
      if (scan_idx == IDX_W'(NUM_DIGITS - 1 - i)) begin
        count_digit = bcd_q[i];
        count_shown = 1'b1;
      end
    end

    slot_glyph = GLYPH_BLANK;
    if (stop_s) begin
      slot_glyph = GLYPH_EIGHT;
    end else if (turn_active) begin
      slot_glyph = GLYPH_DASH;
      if (scan_idx == '0 && stanga_s && blink_visible)
        slot_glyph = GLYPH_LEFT;
      if (scan_idx == IDX_LAST && dreapta_s && blink_visible)
        slot_glyph = GLYPH_RIGHT;
    end else if (count_shown) begin
      slot_glyph = bcd_to_glyph(count_digit);
    end
  end

  assign scan_tick = (prescaler == SCAN_LAST);

  // Scan engine: digit select and segments are loaded on the same tick so a
  // digit never shows its neighbour's pattern.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      scan_idx  <= '0;
      digit_en  <= '0;
      seg       <= SEG_POL;
    end else begin
      prescaler <= scan_tick ? '0 : prescaler + 1'b1;
      if (scan_tick) begin
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        digit_en <= NUM_DIGITS'(1) << scan_idx;
        seg      <= slot_glyph ^ SEG_POL;
      end
    end
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb_seg_display_scanner
// Self-checking bench for seg_display_scanner with a small configuration.
// A behavioural model tracks the counter as an integer, the scan schedule as
// a function of elapsed cycles and the blink phase from the length of the
// current turn-signal streak; one compare process checks every cycle, and
// directed sequences add hand-computed literal checks.
module tb_seg_display_scanner;

  localparam int ND  = 4;
  localparam int CD  = 2;
  localparam int SD  = 4;
  localparam int BD  = 32;
  localparam int CAP = 100;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tact_count = 1'b0;
  logic          clear_count = 1'b0;
  logic          stop = 1'b0;
  logic          semnal_stanga = 1'b0;
  logic          semnal_dreapta = 1'b0;
  logic [ND-1:0] digit_en;
  logic [6:0]    seg;
  logic          count_wrap;

  int n_compared = 0;
  int n_mismatched = 0;

  seg_display_scanner #(
    .NUM_DIGITS(ND), .CNT_DIGITS(CD), .SCAN_DIV(SD), .BLINK_DIV(BD),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tact_count(tact_count),
    .clear_count(clear_count), .stop(stop), .semnal_stanga(semnal_stanga),
    .semnal_dreapta(semnal_dreapta), .digit_en(digit_en), .seg(seg),
    .count_wrap(count_wrap)
  );

  always #5 clock = ~clock;

  // Active-high glyph table for decimal digits.
  logic [6:0] glyph_num [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011};

  // Model state: input histories (bit 0 = sample at this edge), elapsed
  // edges since reset release, counter value and current turn-streak length.
  bit [3:0]      th = '0, sh = '0, lh = '0, rh = '0;
  int            m_t = 0;
  int            m_count = 0;
  int            m_run = 0;
  logic [ND-1:0] exp_en = '0;
  logic [6:0]    exp_seg = 7'h7F;
  logic          exp_wrap = 1'b0;

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  // What position pos must show, given the status seen by the design
  // (inputs from two edges ago) and the counter value before this edge.
  function automatic logic [6:0] model_glyph(input int pos);
    bit vis;
    int dec;
    vis = ((m_run / BD) % 2) == 0;
    if (sh[2]) return 7'b1111111;
    if (lh[2] || rh[2]) begin
      if (pos == 0 && lh[2] && vis) return 7'b1001111;
      if (pos == ND - 1 && rh[2] && vis) return 7'b1111001;
      return 7'b0000001;
    end
    dec = ND - 1 - pos;
    if (dec < CD) return glyph_num[(m_count / pow10(dec)) % 10];
    return 7'b0000000;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      th = '0; sh = '0; lh = '0; rh = '0;
      m_t = 0; m_count = 0; m_run = 0;
      exp_en = '0; exp_seg = 7'h7F; exp_wrap = 1'b0;
    end else begin
      th = {th[2:0], tact_count};
      sh = {sh[2:0], stop};
      lh = {lh[2:0], semnal_stanga};
      rh = {rh[2:0], semnal_dreapta};
      m_t++;
      if (m_t % SD == 0) begin
        int pos;
        pos     = (m_t / SD - 1) % ND;
        exp_en  = ND'(1) << pos;
        exp_seg = ~model_glyph(pos);
      end
      if (clear_count) begin
        m_count  = 0;
        exp_wrap = 1'b0;
      end else if (th[2] && !th[3]) begin
        exp_wrap = (m_count == CAP - 1);
        m_count  = (m_count + 1) % CAP;
      end else begin
        exp_wrap = 1'b0;
      end
      if (lh[2] || rh[2]) m_run++;
      else m_run = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      checkOutput("cyc_digit_en", digit_en, '0);
      checkOutput("cyc_seg", seg, 7'h7F);
      checkOutput("cyc_wrap", count_wrap, 1'b0);
    end else begin
      checkOutput("cyc_digit_en", digit_en, exp_en);
      checkOutput("cyc_seg", seg, exp_seg);
      checkOutput("cyc_wrap", count_wrap, exp_wrap);
    end
  end

  // One tact_count pulse; called and returns on a falling clock edge.
  task automatic applyStimulus(input int hi, input int lo);
    tact_count = 1'b1;
    repeat (hi) @(negedge clock);
    tact_count = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2, 3);
    repeat (4) @(negedge clock);
  endtask

  // Wait for the next fresh selection of position p, then check its segments.
  task automatic checkSlot(input string name, input int p, input logic [6:0] lit);
    logic [ND-1:0] target;
    int guard;
    target = ND'(1) << p;
    guard  = 0;
    while (digit_en == target && guard < 40) begin @(negedge clock); guard++; end
    while (digit_en != target && guard < 40) begin @(negedge clock); guard++; end
    checkOutput({name, "_sel"}, digit_en, target);
    checkOutput(name, seg, lit);
  endtask

  task automatic waitRun(input int n);
    int guard = 0;
    while (m_run < n && guard < 100) begin @(negedge clock); guard++; end
  endtask

  initial begin
    int wrap_hits;
    int wrap_at;

    repeat (3) @(negedge clock);
    checkOutput("reset_en", digit_en, '0);
    checkOutput("reset_seg", seg, 7'h7F);
    checkOutput("reset_wrap", count_wrap, 1'b0);

    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checkOutput("pre_tick_en", digit_en, '0);
    end
    @(negedge clock);
    checkOutput("first_tick_en", digit_en, 4'b0001);
    checkOutput("first_tick_seg", seg, 7'h7F);
    checkSlot("idle_d1", 1, 7'h7F);
    checkSlot("idle_d2", 2, 7'h01);
    checkSlot("idle_d3", 3, 7'h01);
    repeat (20) @(negedge clock);

    pulses(37);
    checkOutput("model_37", m_count, 37);
    checkSlot("cnt37_tens", 2, 7'h06);
    checkSlot("cnt37_units", 3, 7'h0F);
    applyStimulus(20, 10);
    checkOutput("model_wide", m_count, 38);
    checkSlot("wide_units", 3, 7'h00);

    pulses(61);
    checkOutput("model_99", m_count, 99);
    checkSlot("nn_units", 3, 7'h04);
    wrap_hits = 0;
    wrap_at = -1;
    tact_count = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (count_wrap) begin
        wrap_hits++;
        if (wrap_at < 0) wrap_at = i;
      end
      if (i == 1) tact_count = 1'b0;
    end
    checkOutput("wrap_once", wrap_hits, 1);
    checkOutput("wrap_latency", wrap_at, 2);
    checkSlot("wrap_tens", 2, 7'h01);
    checkSlot("wrap_units", 3, 7'h01);

    pulses(99);
    checkOutput("model_99b", m_count, 99);
    tact_count = 1'b1;
    @(negedge clock);
    @(negedge clock);
    clear_count = 1'b1;
    tact_count = 1'b0;
    @(negedge clock);
    clear_count = 1'b0;
    wrap_hits = (count_wrap === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge clock);
      if (count_wrap) wrap_hits++;
    end
    checkOutput("clear_no_wrap", wrap_hits, 0);
    checkOutput("clear_model", m_count, 0);
    checkSlot("clear_tens", 2, 7'h01);
    checkSlot("clear_units", 3, 7'h01);

    pulses(42);
    checkOutput("model_42", m_count, 42);
    semnal_stanga = 1'b1;
    repeat (3) @(negedge clock);
    checkSlot("left_vis", 0, 7'h30);
    checkSlot("left_dash1", 1, 7'h7E);
    checkSlot("left_dash3", 3, 7'h7E);
    waitRun(BD);
    checkSlot("left_hidden", 0, 7'h7E);

    semnal_stanga = 1'b0;
    repeat (5) @(negedge clock);
    semnal_stanga = 1'b1;
    semnal_dreapta = 1'b1;
    repeat (3) @(negedge clock);
    checkSlot("hazard_right", 3, 7'h06);
    checkSlot("hazard_left", 0, 7'h30);
    waitRun(BD);
    checkSlot("hazard_right_off", 3, 7'h7E);
    checkSlot("hazard_left_off", 0, 7'h7E);

    semnal_dreapta = 1'b0;
    stop = 1'b1;
    repeat (3) @(negedge clock);
    checkSlot("stop_d0", 0, 7'h00);
    checkSlot("stop_d2", 2, 7'h00);
    checkSlot("stop_d3", 3, 7'h00);
    stop = 1'b0;
    repeat (3) @(negedge clock);
    checkSlot("stop_drop_d1", 1, 7'h7E);

    clear_count = 1'b1;
    @(negedge clock);
    clear_count = 1'b0;
    pulses(15);
    checkOutput("model_15", m_count, 15);
    repeat (40) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_en", digit_en, '0);
    checkOutput("async_reset_seg", seg, 7'h7F);
    checkOutput("async_reset_wrap", count_wrap, 1'b0);
    semnal_stanga = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkSlot("post_reset_tens", 2, 7'h01);
    checkSlot("post_reset_units", 3, 7'h01);
    checkOutput("post_reset_model", m_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Parametrised successor to the car's multiplexed 7-segment display driver.
- Owns a decimal BCD event counter, driven by `tact_count` pulses (e.g. line-crossing events).
- Time-multiplexes NUM_DIGITS common-anode/cathode digits at a programmable scan rate.
- Overlays status glyphs with fixed priority: stop, then blinking turn indicators, then the count.
- Sits between the line-follower control FSM and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- CNT_DIGITS, 2: BCD decades in the counter (1..NUM_DIGITS).
- SCAN_DIV, 50000: clock cycles per digit slot (>=2).
- BLINK_DIV, 12500000: clock cycles per turn-glyph blink half-period (>=2).
- SEG_ACTIVE_LOW, 1: 1 means a segment is lit when driven 0.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- tact_count  in  1  async level; each rising edge increments the counter.
- clear_count  in  1  sync clear of the counter, active-high.
- stop  in  1  async level, stop status.
- semnal_stanga  in  1  async level, left turn.
- semnal_dreapta  in  1  async level, right turn.
- digit_en  out  NUM_DIGITS  one-hot digit select, active-high; bit 0 = leftmost (D1).
- seg  out  7  segments, {a,b,c,d,e,f,g} = seg[6:0], polarity per SEG_ACTIVE_LOW.
- count_wrap  out  1  one-cycle pulse when the counter wraps from all-9s to 0.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Counter decades, prescaler, scan index, blink counter and synchronisers all clear to 0.
  - Blink phase resets to visible.
  - digit_en=0, seg=all-off (7'h7F when active-low), count_wrap=0.
  - The first digit is driven at the first scan tick after release.
- Input synchronisation: tact_count, stop, semnal_stanga and semnal_dreapta each pass through a 2-FF synchroniser.
- tact_count edge detection: an edge fires when sync2=1 and the previous sync2=0.
  - Input high at edge k gives a counter update at edge k+2.
  - A level held high counts once.
- Counter: CNT_DIGITS-decade BCD, ripple carry within one cycle.
  - Each decade wraps 9 to 0.
  - All-9s + 1 gives all zeros, with count_wrap=1 for that one cycle.
  - clear_count (sampled directly, synchronous) wins over a simultaneous increment: result 0, no count_wrap.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1; terminal count produces a scan tick.
  - On the tick, the index advances modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
  - digit_en and seg are registered together on the tick, so there is no ghosting.
  - Both are stable for exactly SCAN_DIV cycles.
- Glyphs (active-high a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - DASH=0000001, LEFT=1001111, RIGHT=1111001 with segment e off, i.e. 1111001, BLANK=0000000.
  - SEG_ACTIVE_LOW=1 inverts all seven bits at the output register.
- Content of position p (0=left), evaluated at the tick, priority order:
  1. stop_s=1: every position shows 8 (all segments).
  2. Else, if either turn signal is active:
     - Position 0 shows LEFT if semnal_stanga_s and phase visible, else DASH.
     - Position NUM_DIGITS-1 shows RIGHT if semnal_dreapta_s and phase visible, else DASH.
     - Other positions show DASH.
     - Both turn signals active = hazard: both ends blink in phase.
  3. Else (count mode): position p shows decade NUM_DIGITS-1-p if that is < CNT_DIGITS (right-aligned, units at rightmost), else BLANK. Leading zeros are shown.
- Blink:
  - While neither turn signal is active, the blink counter is held at 0 and the phase is visible.
  - While a turn signal is active, the counter runs 0..BLINK_DIV-1 and the phase toggles at terminal count.
  - First assertion therefore shows the glyph for BLINK_DIV cycles.
- Counting continues in stop and turn modes; the display returns to the current value when the overlay drops.
- Reset mid-scan or mid-blink: immediate return to reset values, no partial frame.

Test Plan (NUM_DIGITS=4, CNT_DIGITS=2, SCAN_DIV=4, BLINK_DIV=32, SEG_ACTIVE_LOW=1):
- Release reset, idle 40 cycles:
  - digit_en=0 and seg=7'h7F until the first tick (cycle 4).
  - Then digit_en cycles 0001, 0010, 0100, 1000, 0001, each held 4 cycles.
  - seg is BLANK, BLANK, ~"0", ~"0".
- 37 tact_count pulses, 2 high / 3 low cycles each:
  - Rightmost two digits show ~"3", ~"7".
  - A 20-cycle-wide high pulse counts once.
- Preload 99, then one pulse:
  - Counter reads 00 at input-edge+2.
  - count_wrap high exactly 1 cycle.
  - clear_count asserted in the same cycle as an increment edge yields 00 with no wrap pulse.
- semnal_stanga=1:
  - Position 0 alternates ~LEFT / ~DASH every 32 cycles, starting with LEFT.
  - Positions 1..3 show ~DASH steady.
  - Adding semnal_dreapta makes position 3 blink in phase with position 0.
- stop=1 together with semnal_stanga=1 and count 42: all positions show seg=7'h00; drop stop and the turn display resumes.
- Assert reset_n=0 mid-blink with count 15: outputs go to reset values asynchronously; after release the count displays 00.
